mac_accumulator_n: RTL

Parametrised per-neuron synaptic accumulator. It is the successor of the fixed five-connection MAC.
- A run-time-loadable table maps source addresses to signed fixed-point weights.
- Incoming spike addresses are matched in parallel against the table during a timestep.
- On each timestep boundary the block sequentially sums the weights of every synapse that spiked, then presents the result to the neuron's membrane-potential stage.

---
 rtl/mac_accumulator_n.sv | 99 +++++++++
 1 files changed

// File: rtl/mac_accumulator_n.sv
// mac_accumulator_n: per-neuron synaptic table with parallel spike match and sequential saturating weight sum
module mac_accumulator_n #(
  parameter int NUM_CONN = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                          CLK_Mac,
  input  logic                          RSTN_Mac,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CONN)-1:0]   cfg_index,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]       cfg_weight,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic                          spike_valid,
  input  logic [ADDR_WIDTH-1:0]         spike_addr,
  input  logic                          timestep_end,
  output logic [ACC_WIDTH-1:0]          sum_out,
  output logic                          sum_valid,
  output logic [$clog2(NUM_CONN):0]     active_count,
  output logic                          busy,
  output logic                          overrun
);
  localparam int IW = $clog2(NUM_CONN);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] t_addr [NUM_CONN];
  logic signed [WEIGHT_WIDTH-1:0] t_weight [NUM_CONN];
  logic [NUM_CONN-1:0] t_valid, pending, snapshot, match, wr_clr;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [ACC_WIDTH:0] term, sum_ext;
  logic [IW:0] cnt, cnt_nxt;
  logic [IW-1:0] idx;
  logic we_ok;
  assign busy = state != IDLE;
  assign cfg_ready = !busy;
  always_comb begin
    we_ok = cfg_we && cfg_ready && (32'(cfg_index) < NUM_CONN);
    wr_clr = we_ok ? NUM_CONN'(1) << cfg_index : '0;
    for (int i = 0; i < NUM_CONN; i++) match[i] = spike_valid && t_valid[i] && t_addr[i] == spike_addr;
    term = snapshot[idx] ? (ACC_WIDTH+1)'(t_weight[idx]) : '0;
    sum_ext = {acc[ACC_WIDTH-1], acc} + term;
    // a carry into the guard bit that disagrees with the sign bit means overflow
    acc_nxt = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]
            ? (sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}})
            : sum_ext[ACC_WIDTH-1:0];
    cnt_nxt = cnt + (IW+1)'(snapshot[idx]);
  end
  always_ff @(posedge CLK_Mac) begin
    if (we_ok) begin
      t_addr[cfg_index] <= cfg_addr;
      t_weight[cfg_index] <= cfg_weight;
    end
  end
  always_ff @(posedge CLK_Mac or negedge RSTN_Mac) begin
    if (!RSTN_Mac) begin
      state <= IDLE;
      t_valid <= '0;
      pending <= '0;
      snapshot <= '0;
      acc <= '0;
      cnt <= '0;
      idx <= '0;
      sum_out <= '0;
      sum_valid <= 1'b0;
      active_count <= '0;
      overrun <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      pending <= (pending | match) & ~wr_clr;
      if (we_ok) t_valid[cfg_index] <= cfg_valid;
      if (timestep_end && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (timestep_end) begin
          snapshot <= pending;
          pending <= match & ~wr_clr;
          acc <= '0;
          cnt <= '0;
          idx <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          idx <= idx + 1'b1;
          // result is published on entry to DONE so it is valid during the sum_valid cycle
          if (32'(idx) == NUM_CONN - 1) begin
            sum_out <= acc_nxt;
            active_count <= cnt_nxt;
            sum_valid <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
